// File: rtl/ahb3lite_burst_master.sv
// AHB3-Lite incrementing burst master.
// Takes one burst request at a time and runs it as a sequence of address and data phases.
// Write data arrives on a valid/ready stream. Read data leaves on a valid-only stream.
// If a write word is late, the burst pauses: HTRANS shows BUSY mid-burst, or IDLE before a
// NONSEQ beat. A slave ERROR stops the burst, drains the write words still owed, and
// reports err together with done.
module ahb3lite_burst_master #(
    parameter int          HADDR_SIZE = 32,
    parameter int          HDATA_SIZE = 32,
    parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    // request port
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [HADDR_SIZE-1:0]  req_addr,
    input  logic                   req_write,
    input  logic [2:0]             req_size,
    input  logic [4:0]             req_len,
    // write stream
    input  logic                   wdat_valid,
    output logic                   wdat_ready,
    input  logic [HDATA_SIZE-1:0]  wdat_data,
    // read stream
    output logic                   rdat_valid,
    output logic [HDATA_SIZE-1:0]  rdat_data,
    output logic                   rdat_last,
    // status
    output logic                   done,
    output logic                   err,
    // AHB master
    output logic [HADDR_SIZE-1:0]  HADDR,
    output logic                   HWRITE,
    output logic [2:0]             HSIZE,
    output logic [2:0]             HBURST,
    output logic [3:0]             HPROT,
    output logic [1:0]             HTRANS,
    output logic                   HMASTLOCK,
    output logic [HDATA_SIZE-1:0]  HWDATA,
    input  logic [HDATA_SIZE-1:0]  HRDATA,
    input  logic                   HREADY,
    input  logic                   HRESP
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;
    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NONSEQ = 2'b10, T_SEQ = 2'b11;

    state_t                 state_q, state_d;
    logic [HADDR_SIZE-1:0]  haddr_q, haddr_d, haddr_nxt, inc;
    logic [1:0]             htrans_q, htrans_d, kind;
    logic                   hwrite_q, hwrite_d;
    logic [2:0]             hsize_q, hsize_d, hburst_q, hburst_d, burst_sel;
    logic [HDATA_SIZE-1:0]  hwdata_q, hwdata_d;
    logic [4:0]             beats_q, beats_d, fetch_q, fetch_d, len_eff, rem;
    logic                   dp_act_q, dp_act_d, dp_last_q, dp_last_d;
    logic                   done_q, done_d, err_q, err_d;
    logic                   buf_full_q, buf_full_d;
    logic [HDATA_SIZE-1:0]  buf_q, buf_d, wcur_q, wcur_d, word;
    logic                   wdat_fire, avail, active, dp_err;
    logic [12:0]            span;

    assign len_eff   = (req_len == 5'd0) ? 5'd1 : req_len;
    assign span      = 13'(req_addr[9:0]) + (13'(len_eff) << req_size);
    assign inc       = {{(HADDR_SIZE-1){1'b0}}, 1'b1} << hsize_q;
    assign haddr_nxt = haddr_q + inc;
    assign active    = htrans_q[1];
    assign dp_err    = dp_act_q & HRESP & ~HREADY;
    assign wdat_fire = wdat_valid & wdat_ready;
    // word for the next beat: the parked one takes priority, otherwise the one arriving now
    assign avail     = buf_full_q | wdat_fire;
    assign word      = buf_full_q ? buf_q : wdat_data;

    // burst encoding; a burst that crosses a 1KB boundary is issued as undefined-length INCR
    always_comb begin
        unique case (len_eff)
            5'd1:    burst_sel = 3'b000;
            5'd4:    burst_sel = 3'b011;
            5'd8:    burst_sel = 3'b101;
            5'd16:   burst_sel = 3'b111;
            default: burst_sel = 3'b001;
        endcase
        if (span > 13'd1024) burst_sel = 3'b001;
    end

    // write words are taken at accept, while beats are still owed, and while draining after an error
    always_comb begin
        wdat_ready = 1'b0;
        unique case (state_q)
            IDLE:    wdat_ready = req_valid & req_write;
            ADDR:    wdat_ready = hwrite_q & ~buf_full_q & (fetch_q != 5'd0);
            ERR:     wdat_ready = (fetch_q != 5'd0);
            default: wdat_ready = 1'b0;
        endcase
    end

    // next-state and next values of every registered output
    always_comb begin
        state_d    = state_q;
        haddr_d    = haddr_q;
        htrans_d   = htrans_q;
        hwrite_d   = hwrite_q;
        hsize_d    = hsize_q;
        hburst_d   = hburst_q;
        hwdata_d   = hwdata_q;
        beats_d    = beats_q;
        fetch_d    = fetch_q;
        dp_act_d   = dp_act_q;
        dp_last_d  = dp_last_q;
        buf_full_d = buf_full_q;
        buf_d      = buf_q;
        wcur_d     = wcur_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        rem        = beats_q;
        kind       = T_NONSEQ;
        if (wdat_fire) fetch_d = fetch_q - 5'd1;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d   = ADDR;
                    haddr_d   = req_addr;
                    hwrite_d  = req_write;
                    hsize_d   = req_size;
                    hburst_d  = burst_sel;
                    beats_d   = len_eff;
                    dp_last_d = 1'b0;
                    fetch_d   = req_write ? len_eff - 5'(wdat_fire) : 5'd0;
                    htrans_d  = (!req_write || wdat_fire) ? T_NONSEQ : T_IDLE;
                    if (wdat_fire) wcur_d = wdat_data;
                end
            end
            ADDR: begin
                if (dp_err) begin
                    state_d    = ERR;
                    htrans_d   = T_IDLE;
                    buf_full_d = 1'b0;
                end else begin
                    // park an early word; overridden below if it is issued right away
                    if (wdat_fire) begin
                        buf_full_d = 1'b1;
                        buf_d      = wdat_data;
                    end
                    if (HREADY) begin
                        dp_act_d = active;
                        if (active) begin
                            if (hwrite_q) hwdata_d = wcur_q;
                            beats_d   = beats_q - 5'd1;
                            dp_last_d = (beats_q == 5'd1);
                            haddr_d   = haddr_nxt;
                            rem       = beats_q - 5'd1;
                            kind      = (haddr_nxt[9:0] == 10'd0) ? T_NONSEQ : T_SEQ;
                        end else begin
                            kind      = (htrans_q == T_BUSY) ? T_SEQ : T_NONSEQ;
                        end
                        if (rem == 5'd0) begin
                            htrans_d = T_IDLE;
                            state_d  = DATA;
                        end else if (!hwrite_q || avail) begin
                            htrans_d = kind;
                            if (hwrite_q) begin
                                wcur_d     = word;
                                buf_full_d = 1'b0;
                            end
                        end else begin
                            htrans_d = (kind == T_SEQ) ? T_BUSY : T_IDLE;
                        end
                    end
                end
            end
            DATA: begin
                if (dp_err) begin
                    state_d  = ERR;
                    htrans_d = T_IDLE;
                end else if (HREADY && dp_act_q) begin
                    dp_act_d = 1'b0;
                    if (dp_last_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            ERR: begin
                if (HREADY) dp_act_d = 1'b0;
                if (!dp_act_q && fetch_q == 5'd0) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and registered outputs; reset abandons any burst without reporting done
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= IDLE;
            haddr_q    <= '0;
            htrans_q   <= T_IDLE;
            hwrite_q   <= 1'b0;
            hsize_q    <= 3'd0;
            hburst_q   <= 3'd0;
            hwdata_q   <= '0;
            beats_q    <= 5'd0;
            fetch_q    <= 5'd0;
            dp_act_q   <= 1'b0;
            dp_last_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            buf_full_q <= 1'b0;
            buf_q      <= '0;
            wcur_q     <= '0;
        end else begin
            state_q    <= state_d;
            haddr_q    <= haddr_d;
            htrans_q   <= htrans_d;
            hwrite_q   <= hwrite_d;
            hsize_q    <= hsize_d;
            hburst_q   <= hburst_d;
            hwdata_q   <= hwdata_d;
            beats_q    <= beats_d;
            fetch_q    <= fetch_d;
            dp_act_q   <= dp_act_d;
            dp_last_q  <= dp_last_d;
            done_q     <= done_d;
            err_q      <= err_d;
            buf_full_q <= buf_full_d;
            buf_q      <= buf_d;
            wcur_q     <= wcur_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign rdat_valid = dp_act_q & ~hwrite_q & HREADY & ~HRESP;
    assign rdat_data  = HRDATA;
    assign rdat_last  = rdat_valid & dp_last_q;
    assign done       = done_q;
    assign err        = err_q;
    assign HADDR      = haddr_q;
    assign HWRITE     = hwrite_q;
    assign HSIZE      = hsize_q;
    assign HBURST     = hburst_q;
    assign HPROT      = HPROT_VAL;
    assign HTRANS     = htrans_q;
    assign HMASTLOCK  = 1'b0;
    assign HWDATA     = hwdata_q;

endmodule

// File: tb/tb_ahb3lite_burst_master.sv
// Directed bench for ahb3lite_burst_master: reset, read/write bursts, 1KB split,
// write stalls, slave wait states, error response, and reset mid-burst.
module tb_ahb3lite_burst_master;
    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic [4:0]  req_len;
    logic        wdat_valid, wdat_ready;
    logic [31:0] wdat_data;
    logic        rdat_valid, rdat_last, done, err;
    logic [31:0] rdat_data;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic        HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;

    int          vecs = 0;
    int          errs = 0;
    logic [7:0]  widx = 8'd0;
    logic        wen = 1'b0;

    function automatic logic [31:0] wd(input logic [7:0] i);
        return {24'hC0FFEE, i};
    endfunction

    always #5 HCLK = ~HCLK;

    // write source: word index advances on each accepted handshake
    assign wdat_valid = wen;
    assign wdat_data  = wd(widx);
    always @(posedge HCLK) if (wdat_valid && wdat_ready) widx <= widx + 8'd1;

    ahb3lite_burst_master dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_size(req_size), .req_len(req_len),
        .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat_data(wdat_data),
        .rdat_valid(rdat_valid), .rdat_data(rdat_data), .rdat_last(rdat_last),
        .done(done), .err(err),
        .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP)
    );

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [31:0] a, input logic w, input logic [4:0] n);
        req_valid = 1'b1; req_addr = a; req_write = w; req_size = 3'd2; req_len = n;
    endtask

    initial begin
        logic [7:0] b;
        req_valid = 0; req_addr = 0; req_write = 0; req_size = 0; req_len = 0;
        HRDATA = 0; HREADY = 1; HRESP = 0;

        // reset state
        repeat (2) @(posedge HCLK);
        #2;
        chk("rst_htrans", HTRANS, 0);    chk("rst_haddr", HADDR, 0);
        chk("rst_hwrite", HWRITE, 0);    chk("rst_hburst", HBURST, 0);
        chk("rst_hsize", HSIZE, 0);      chk("rst_hwdata", HWDATA, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_wdat_ready", wdat_ready, 0);
        chk("rst_rdat_valid", rdat_valid, 0);
        chk("rst_done", done, 0);        chk("rst_err", err, 0);
        chk("hprot", HPROT, 4'b0011);    chk("hmastlock", HMASTLOCK, 0);
        HRESETn = 1'b1;

        // read len 4 at 0x100, zero wait
        cyc(); req(32'h100, 1'b0, 5'd4); #1;
        chk("r4_accept_ready", req_ready, 1);
        cyc(); req_valid = 0; #1;
        chk("r4_t1_htrans", HTRANS, 2'b10); chk("r4_t1_haddr", HADDR, 32'h100);
        chk("r4_hburst", HBURST, 3'b011);   chk("r4_hsize", HSIZE, 3'd2);
        chk("r4_hwrite", HWRITE, 0);        chk("r4_busy_ready", req_ready, 0);
        for (int k = 1; k <= 4; k++) begin
            cyc(); HRDATA = 32'hA000_0000 + k; #1;
            chk("r4_htrans", HTRANS, (k < 4) ? 2'b11 : 2'b00);
            if (k < 4) chk("r4_haddr", HADDR, 32'h100 + 4 * k);
            chk("r4_rvalid", rdat_valid, 1);
            chk("r4_rdata", rdat_data, 32'hA000_0000 + k);
            chk("r4_rlast", rdat_last, k == 4);
        end
        cyc(); #1;
        chk("r4_done", done, 1); chk("r4_err", err, 0); chk("r4_rvalid_end", rdat_valid, 0);
        cyc(); #1;
        chk("r4_done_pulse", done, 0);

        // write len 3 at 0x3F8: crosses 1KB, beat at 0x400 restarts as NONSEQ
        cyc(); b = widx; wen = 1; req(32'h3F8, 1'b1, 5'd3); #1;
        chk("w3_accept_wready", wdat_ready, 1);
        cyc(); req_valid = 0; #1;
        chk("w3_t1_htrans", HTRANS, 2'b10); chk("w3_t1_haddr", HADDR, 32'h3F8);
        chk("w3_hburst", HBURST, 3'b001);   chk("w3_hwrite", HWRITE, 1);
        cyc(); #1;
        chk("w3_t2_htrans", HTRANS, 2'b11); chk("w3_t2_haddr", HADDR, 32'h3FC);
        chk("w3_t2_hwdata", HWDATA, wd(b));
        cyc(); #1;
        chk("w3_t3_htrans", HTRANS, 2'b10); chk("w3_t3_haddr", HADDR, 32'h400);
        chk("w3_t3_hwdata", HWDATA, wd(b + 8'd1)); chk("w3_t3_wready", wdat_ready, 0);
        wen = 0;
        cyc(); #1;
        chk("w3_t4_htrans", HTRANS, 2'b00); chk("w3_t4_hwdata", HWDATA, wd(b + 8'd2));
        cyc(); #1;
        chk("w3_done", done, 1); chk("w3_err", err, 0);

        // write len 4 at 0x200 with the third word two cycles late
        cyc(); b = widx; wen = 1; req(32'h200, 1'b1, 5'd4); #1;
        cyc(); req_valid = 0; #1;
        chk("w4_t1_htrans", HTRANS, 2'b10); chk("w4_hburst", HBURST, 3'b011);
        cyc(); wen = 0; #1;
        chk("w4_t2_htrans", HTRANS, 2'b11); chk("w4_t2_haddr", HADDR, 32'h204);
        chk("w4_t2_hwdata", HWDATA, wd(b));
        cyc(); #1;
        chk("w4_t3_busy", HTRANS, 2'b01); chk("w4_t3_haddr", HADDR, 32'h208);
        chk("w4_t3_hwdata", HWDATA, wd(b + 8'd1));
        cyc(); wen = 1; #1;
        chk("w4_t4_busy", HTRANS, 2'b01); chk("w4_t4_haddr", HADDR, 32'h208);
        chk("w4_t4_wready", wdat_ready, 1);
        cyc(); #1;
        chk("w4_t5_htrans", HTRANS, 2'b11); chk("w4_t5_haddr", HADDR, 32'h208);
        chk("w4_t5_hwdata", HWDATA, wd(b + 8'd1));
        cyc(); wen = 0; #1;
        chk("w4_t6_htrans", HTRANS, 2'b11); chk("w4_t6_haddr", HADDR, 32'h20C);
        chk("w4_t6_hwdata", HWDATA, wd(b + 8'd2));
        cyc(); #1;
        chk("w4_t7_htrans", HTRANS, 2'b00); chk("w4_t7_hwdata", HWDATA, wd(b + 8'd3));
        cyc(); #1;
        chk("w4_done", done, 1);

        // read len 8 at 0x300, slave inserts two wait states on beat 2
        cyc(); req(32'h300, 1'b0, 5'd8); #1;
        cyc(); req_valid = 0; #1;
        chk("r8_hburst", HBURST, 3'b101);
        for (int c = 2; c <= 13; c++) begin
            cyc(); HREADY = !(c == 2 || c == 3); HRDATA = 32'hB000_0000 + c; #1;
            if (c == 2 || c == 3) begin
                chk("r8_wait_haddr", HADDR, 32'h304); chk("r8_wait_htrans", HTRANS, 2'b11);
            end
            chk("r8_rvalid", rdat_valid, c >= 4 && c <= 11);
            chk("r8_rlast", rdat_last, c == 11);
            chk("r8_done", done, c == 12);
        end
        HREADY = 1;

        // write len 4 at 0x500, ERROR response on beat 2
        cyc(); b = widx; wen = 1; req(32'h500, 1'b1, 5'd4); #1;
        cyc(); req_valid = 0; #1;
        cyc(); #1;
        chk("we_t2_hwdata", HWDATA, wd(b));
        cyc(); HREADY = 0; HRESP = 1; #1;
        chk("we_t3_htrans", HTRANS, 2'b11); chk("we_t3_haddr", HADDR, 32'h508);
        cyc(); HREADY = 1; HRESP = 1; wen = 0; #1;
        chk("we_t4_htrans", HTRANS, 2'b00); chk("we_t4_hwdata", HWDATA, wd(b + 8'd1));
        chk("we_t4_rvalid", rdat_valid, 0);
        cyc(); HRESP = 0; #1;
        chk("we_t5_htrans", HTRANS, 2'b00); chk("we_t5_done", done, 0);
        chk("we_words_taken", widx - b, 8'd4);
        cyc(); #1;
        chk("we_done", done, 1); chk("we_err", err, 1);
        cyc(); #1;
        chk("we_done_pulse", done, 0); chk("we_ready", req_ready, 1);

        // read len 16 at 0x0, reset during beat 3
        cyc(); req(32'h0, 1'b0, 5'd16); #1;
        cyc(); req_valid = 0; #1;
        chk("rr_hburst", HBURST, 3'b111);
        cyc(); #1;
        cyc(); #1;
        chk("rr_t3_haddr", HADDR, 32'h8);
        HRESETn = 0; #1;
        chk("rr_rst_htrans", HTRANS, 0); chk("rr_rst_haddr", HADDR, 0);
        chk("rr_rst_hburst", HBURST, 0); chk("rr_rst_ready", req_ready, 1);
        chk("rr_rst_rvalid", rdat_valid, 0);
        cyc(); HRESETn = 1; #1;
        for (int k = 0; k < 3; k++) begin
            cyc(); #1;
            chk("rr_no_done", done, 0); chk("rr_idle", HTRANS, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/ahb3lite_burst_master.md
AHB3LITE_BURST_MASTER -- requirements
Module: ahb3lite_burst_master

Interface
REQ-001 SHALL have parameter HADDR_SIZE, default 32, AHB address width.
REQ-002 SHALL have parameter HDATA_SIZE, default 32, AHB data width.
REQ-003 SHALL have parameter HPROT_VAL, default 4'b0011, constant driven on HPROT.
REQ-004 Clock and reset: HCLK in 1, clock; HRESETn in 1, reset, asynchronous, active-low.
REQ-005 Request port: req_valid in 1; req_ready out 1; req_addr in HADDR_SIZE; req_write in 1; req_size in 3 (HSIZE encoding); req_len in 5 (beats, 1..16, 0 treated as 1).
REQ-006 Write stream: wdat_valid in 1; wdat_ready out 1; wdat_data in HDATA_SIZE.
REQ-007 Read stream: rdat_valid out 1; rdat_data out HDATA_SIZE; rdat_last out 1; no backpressure.
REQ-008 Status: done out 1, one-cycle pulse at request end; err out 1, valid with done.
REQ-009 AHB master: HADDR out HADDR_SIZE; HWRITE out 1; HSIZE out 3; HBURST out 3; HPROT out 4; HTRANS out 2; HMASTLOCK out 1 (tied 0); HWDATA out HDATA_SIZE; HRDATA in HDATA_SIZE; HREADY in 1; HRESP in 1.

Function
REQ-010 Request SHALL be accepted on req_valid & req_ready; req_ready SHALL be 1 only in state IDLE.
REQ-011 States SHALL be IDLE, ADDR, DATA, ERR; all AHB address-phase outputs SHALL be registered.
REQ-012 IDLE->ADDR on accept; first address phase (HTRANS=NONSEQ) SHALL appear the cycle after accept.
REQ-013 ADDR: each beat address phase SHALL advance only when HREADY=1; beats after the first SHALL be SEQ.
REQ-014 Address increment SHALL be 2^req_size bytes, HADDR_SIZE-bit wrap-around.
REQ-015 HBURST SHALL be SINGLE for len 1, INCR4/INCR8/INCR16 for len 4/8/16, otherwise INCR.
REQ-016 If the burst would cross a 1KB boundary, HBURST SHALL be INCR for the whole request and the first beat past the boundary SHALL be NONSEQ.
REQ-017 Write: a beat address phase SHALL be issued only with a captured write word; if none, HTRANS SHALL be BUSY (mid-burst) with HADDR held.
REQ-018 Write buffer SHALL hold one word; wdat_ready=1 when buffer empty, request writes and beats remain unfetched.
REQ-019 HWDATA SHALL load the buffered word when its address phase completes (HREADY=1), holding until the next such completion.
REQ-020 Read: rdat_valid SHALL pulse for each data phase completing with HREADY=1, HRESP=0; rdat_data=HRDATA; rdat_last on final beat.
REQ-021 After the last address phase completes, HTRANS SHALL be IDLE; DATA waits for the last data phase.
REQ-022 done SHALL pulse the cycle after the last data phase completes; err=0; then IDLE.
REQ-023 HRESP=1 with HREADY=0 SHALL force HTRANS=IDLE next cycle and enter ERR; no further beats issued.
REQ-024 ERR: remaining write words SHALL be accepted and discarded; then done=1, err=1, IDLE.
REQ-025 An errored read beat SHALL NOT assert rdat_valid.
REQ-026 Zero-wait slave, N beats, accept at T: address phases T+1..T+N, data T+2..T+N+1, done T+N+2.

Reset
REQ-027 On HRESETn low, asynchronously: HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HBURST=0, HWDATA=0, req_ready=1, wdat_ready=0, rdat_valid=0, rdat_last=0, done=0, err=0, state IDLE, buffer empty.
REQ-028 Reset mid-burst SHALL abandon the request without done.

Verification
REQ-029 Read len=4, size=WORD, addr 0x100, HREADY=1 -> NONSEQ 0x100, SEQ 0x104/0x108/0x10C, HBURST=INCR4, 4 rdat_valid, rdat_last on 4th, done at T+6.
REQ-030 Write len=3, addr 0x3F8, WORD -> HBURST=INCR; 0x3F8 NONSEQ, 0x3FC SEQ, 0x400 NONSEQ; HWDATA matches words.
REQ-031 Write len=4, wdat_valid low 2 cycles before beat 3 -> HTRANS=BUSY 2 cycles, HADDR held, data order preserved.
REQ-032 Read len=8, HREADY=0 2 cycles on beat 2 -> HADDR/HTRANS held; 8 rdat_valid; done once.
REQ-033 Write len=4, ERROR response on beat 2 -> HTRANS=IDLE after first error cycle, words 3-4 discarded, done=1 err=1.
REQ-034 HRESETn low during beat 3 of len=16 read -> outputs at reset values immediately, req_ready=1, no done.
